// File: rtl/axi4lite_remote_proxy_if.sv
// Bus bundle for the AXI4-Lite remote proxy:
// local AXI4-Lite slave port, AXIS request out, AXIS response in.
interface axi4lite_remote_proxy_if #(
    parameter int DATA_WIDTH = 256
);
    logic [31:0]           S_AXI_AWADDR;
    logic                  S_AXI_AWVALID;
    logic                  S_AXI_AWREADY;
    logic [31:0]           S_AXI_WDATA;
    logic [3:0]            S_AXI_WSTRB;
    logic                  S_AXI_WVALID;
    logic                  S_AXI_WREADY;
    logic [1:0]            S_AXI_BRESP;
    logic                  S_AXI_BVALID;
    logic                  S_AXI_BREADY;
    logic [31:0]           S_AXI_ARADDR;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;
    logic [31:0]           S_AXI_RDATA;
    logic [1:0]            S_AXI_RRESP;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY;
    logic [DATA_WIDTH-1:0] AXIS_TX_TDATA;
    logic                  AXIS_TX_TVALID;
    logic                  AXIS_TX_TREADY;
    logic [DATA_WIDTH-1:0] AXIS_RSP_TDATA;
    logic                  AXIS_RSP_TVALID;
    logic                  AXIS_RSP_TREADY;

    // Proxy side: AXI-Lite slave, AXIS request source, AXIS response sink.
    modport slave (
        input  S_AXI_AWADDR,
        input  S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA,
        input  S_AXI_WSTRB,
        input  S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP,
        output S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR,
        input  S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA,
        output S_AXI_RRESP,
        output S_AXI_RVALID,
        input  S_AXI_RREADY,
        output AXIS_TX_TDATA,
        output AXIS_TX_TVALID,
        input  AXIS_TX_TREADY,
        input  AXIS_RSP_TDATA,
        input  AXIS_RSP_TVALID,
        output AXIS_RSP_TREADY
    );

    // Environment side: AXI-Lite master, link sink, broker source.
    modport master (
        output S_AXI_AWADDR,
        output S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA,
        output S_AXI_WSTRB,
        output S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP,
        input  S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR,
        output S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA,
        input  S_AXI_RRESP,
        input  S_AXI_RVALID,
        output S_AXI_RREADY,
        input  AXIS_TX_TDATA,
        input  AXIS_TX_TVALID,
        output AXIS_TX_TREADY,
        output AXIS_RSP_TDATA,
        output AXIS_RSP_TVALID,
        input  AXIS_RSP_TREADY
    );
endinterface

// File: rtl/axi4lite_remote_proxy.sv
// AXI4-Lite slave that tunnels each access as a 256-bit request
// message and completes B/R from the tagged response stream.
module axi4lite_remote_proxy #(
    parameter int          DATA_WIDTH     = 256,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   resetn,
    axi4lite_remote_proxy_if.slave bus,
    output logic [15:0]            stale_count,
    output logic [15:0]            timeout_count
);

    localparam int          MSG_W    = DATA_WIDTH;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  OP_WR    = 8'd1;
    localparam logic [7:0]  OP_RD    = 8'd2;
    localparam logic [1:0]  DECERR   = 2'b11;
    localparam logic [31:0] TMO_DATA = 32'hDEADDEAD;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_RSP,
        RESP_B,
        RESP_R
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             aw_rdy;
    logic             ar_rdy;
    logic [MSG_W-1:0] tx_data;
    logic             tx_valid;
    logic             bvalid;
    logic [1:0]       bresp;
    logic             rvalid;
    logic [1:0]       rresp;
    logic [31:0]      rdata;
    logic             rsp_rdy;
    logic [7:0]       tag;
    logic [31:0]      timer;
    logic             op_rd;

    logic             tx_hs;
    logic             rsp_hs;
    logic             in_wait;
    logic             rsp_hit;
    logic             tmo_hit;
    logic             tmo_evt;
    logic             rsp_stale;
    logic [7:0]       rsp_tag;
    logic [1:0]       rsp_resp;
    logic [31:0]      rsp_rdata;
    logic             unused_rsp_bits;

    function automatic logic [MSG_W-1:0] req_msg(
        input logic [7:0]  op,
        input logic [7:0]  tg,
        input logic [3:0]  strb,
        input logic [31:0] addr,
        input logic [31:0] data
    );
        return {8'h00, op, tg, 164'd0, strb, addr, data};
    endfunction

    assign rsp_tag   = bus.AXIS_RSP_TDATA[239:232];
    assign rsp_resp  = bus.AXIS_RSP_TDATA[33:32];
    assign rsp_rdata = bus.AXIS_RSP_TDATA[31:0];

    assign unused_rsp_bits = ^{bus.AXIS_RSP_TDATA[MSG_W-1:240],
                               bus.AXIS_RSP_TDATA[231:34]};

    assign tx_hs     = tx_valid & bus.AXIS_TX_TREADY;
    assign rsp_hs    = rsp_rdy & bus.AXIS_RSP_TVALID;
    assign in_wait   = (state == WAIT_RSP);
    assign rsp_hit   = in_wait & rsp_hs & (rsp_tag == tag);
    assign tmo_hit   = in_wait & (timer == TMO_LAST);
    assign tmo_evt   = tmo_hit & ~rsp_hit;
    assign rsp_stale = rsp_hs & ~rsp_hit;

    assign bus.S_AXI_AWREADY   = aw_rdy;
    assign bus.S_AXI_WREADY    = aw_rdy;
    assign bus.S_AXI_ARREADY   = ar_rdy;
    assign bus.S_AXI_BVALID    = bvalid;
    assign bus.S_AXI_BRESP     = bresp;
    assign bus.S_AXI_RVALID    = rvalid;
    assign bus.S_AXI_RRESP     = rresp;
    assign bus.S_AXI_RDATA     = rdata;
    assign bus.AXIS_TX_TDATA   = tx_data;
    assign bus.AXIS_TX_TVALID  = tx_valid;
    assign bus.AXIS_RSP_TREADY = rsp_rdy;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the combinational AXI-Lite readies (IDLE only, write wins).
    always_comb begin
        state_nxt = state;
        aw_rdy    = 1'b0;
        ar_rdy    = 1'b0;
        unique case (state)
            IDLE: begin
                aw_rdy = bus.S_AXI_AWVALID & bus.S_AXI_WVALID;
                ar_rdy = bus.S_AXI_ARVALID & ~aw_rdy;
                if (aw_rdy || ar_rdy) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (tx_hs) begin
                    state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rsp_hit || tmo_hit) begin
                    state_nxt = op_rd ? RESP_R : RESP_B;
                end
            end
            RESP_B: begin
                if (bus.S_AXI_BREADY) begin
                    state_nxt = IDLE;
                end
            end
            RESP_R: begin
                if (bus.S_AXI_RREADY) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request build, response capture, timer and tag advance.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= 2'b00;
            rvalid   <= 1'b0;
            rresp    <= 2'b00;
            rdata    <= 32'd0;
            rsp_rdy  <= 1'b0;
            tag      <= 8'd0;
            timer    <= 32'd0;
            op_rd    <= 1'b0;
        end else begin
            rsp_rdy <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (aw_rdy) begin
                        tx_data  <= req_msg(OP_WR, tag,
                                            bus.S_AXI_WSTRB,
                                            bus.S_AXI_AWADDR,
                                            bus.S_AXI_WDATA);
                        tx_valid <= 1'b1;
                        op_rd    <= 1'b0;
                    end else if (ar_rdy) begin
                        tx_data  <= req_msg(OP_RD, tag, 4'd0,
                                            bus.S_AXI_ARADDR,
                                            32'd0);
                        tx_valid <= 1'b1;
                        op_rd    <= 1'b1;
                    end
                end
                SEND: begin
                    if (tx_hs) begin
                        tx_valid <= 1'b0;
                        timer    <= 32'd0;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_hit) begin
                        if (op_rd) begin
                            rvalid <= 1'b1;
                            rresp  <= rsp_resp;
                            rdata  <= rsp_rdata;
                        end else begin
                            bvalid <= 1'b1;
                            bresp  <= rsp_resp;
                        end
                    end else if (tmo_hit) begin
                        if (op_rd) begin
                            rvalid <= 1'b1;
                            rresp  <= DECERR;
                            rdata  <= TMO_DATA;
                        end else begin
                            bvalid <= 1'b1;
                            bresp  <= DECERR;
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                RESP_B: begin
                    if (bus.S_AXI_BREADY) begin
                        bvalid <= 1'b0;
                        tag    <= tag + 8'd1;
                    end
                end
                RESP_R: begin
                    if (bus.S_AXI_RREADY) begin
                        rvalid <= 1'b0;
                        tag    <= tag + 8'd1;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

    // Saturating counters for discarded responses and timeouts.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stale_count   <= 16'd0;
            timeout_count <= 16'd0;
        end else begin
            if (rsp_stale && (stale_count != 16'hFFFF)) begin
                stale_count <= stale_count + 16'd1;
            end
            if (tmo_evt && (timeout_count != 16'hFFFF)) begin
                timeout_count <= timeout_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_remote_proxy.sv
// Bench for axi4lite_remote_proxy: vector table, directed
// corner sequences and a randomized run against a transaction model.
module tb_axi4lite_remote_proxy;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] stale_count;
    logic [15:0] timeout_count;

    always #5 clk = ~clk;

    axi4lite_remote_proxy_if #(.DATA_WIDTH(256)) bus ();

    axi4lite_remote_proxy #(
        .DATA_WIDTH    (256),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .stale_count  (stale_count),
        .timeout_count(timeout_count)
    );

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          tx_stall;
        int          nw;
        int          k;
        bit          drop;
        logic [1:0]  rsp;
        logic [31:0] rdata;
        int          r_stall;
        logic [7:0]  e_tag;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        bit          e_tmo;
        int          e_stale;
        int          e_tmo_cnt;
    } vec_t;

    vec_t tbl[9];

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_tag;
    int         m_stale;
    int         m_tmo;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %064h required %064h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] req_msg(input bit rd,
                                             input logic [7:0] tg,
                                             input logic [3:0] strb,
                                             input logic [31:0] addr,
                                             input logic [31:0] data);
        logic [255:0] m;
        m = '0;
        m[247:240] = rd ? 8'd2 : 8'd1;
        m[239:232] = tg;
        m[63:32]   = addr;
        if (!rd) begin
            m[67:64] = strb;
            m[31:0]  = data;
        end
        return m;
    endfunction

    function automatic logic cur_valid(input bit rd);
        return rd ? bus.S_AXI_RVALID : bus.S_AXI_BVALID;
    endfunction

    task automatic idle_inputs;
        bus.S_AXI_AWADDR    = '0;
        bus.S_AXI_AWVALID   = 1'b0;
        bus.S_AXI_WDATA     = '0;
        bus.S_AXI_WSTRB     = '0;
        bus.S_AXI_WVALID    = 1'b0;
        bus.S_AXI_BREADY    = 1'b0;
        bus.S_AXI_ARADDR    = '0;
        bus.S_AXI_ARVALID   = 1'b0;
        bus.S_AXI_RREADY    = 1'b0;
        bus.AXIS_TX_TREADY  = 1'b0;
        bus.AXIS_RSP_TDATA  = '0;
        bus.AXIS_RSP_TVALID = 1'b0;
    endtask

    // Response beat with junk in the ignored bits.
    task automatic send_rsp(input logic [7:0] tg, input logic [1:0] rs,
                            input logic [31:0] rdat);
        logic [255:0] m;
        m = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        m[239:232] = tg;
        m[33:32]   = rs;
        m[31:0]    = rdat;
        bus.AXIS_RSP_TDATA  = m;
        bus.AXIS_RSP_TVALID = 1'b1;
        tick;
        bus.AXIS_RSP_TVALID = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs;
        resetn = 1'b0;
        tick;
        tick;
        chk("rst_tx_tvalid", bus.AXIS_TX_TVALID, 0);
        chk_w("rst_tx_tdata", bus.AXIS_TX_TDATA, '0);
        chk("rst_bvalid", bus.S_AXI_BVALID, 0);
        chk("rst_rvalid", bus.S_AXI_RVALID, 0);
        chk("rst_bresp_rresp", {bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 0);
        chk("rst_rdata", bus.S_AXI_RDATA, 0);
        chk("rst_rsp_tready", bus.AXIS_RSP_TREADY, 0);
        chk("rst_counters", {stale_count, timeout_count}, 0);
        resetn = 1'b1;
        tick;
        chk("rsp_tready_after_rst", bus.AXIS_RSP_TREADY, 1);
        m_tag   = 8'd0;
        m_stale = 0;
        m_tmo   = 0;
    endtask

    // One full transaction; all expectations come from v.
    task automatic run_txn(input vec_t v);
        logic [255:0] exp_msg;
        int           w;
        exp_msg = req_msg(v.rd, v.e_tag, v.strb, v.addr, v.wdata);
        if (v.rd) begin
            bus.S_AXI_ARADDR  = v.addr;
            bus.S_AXI_ARVALID = 1'b1;
        end else begin
            bus.S_AXI_AWADDR  = v.addr;
            bus.S_AXI_WDATA   = v.wdata;
            bus.S_AXI_WSTRB   = v.strb;
            bus.S_AXI_AWVALID = 1'b1;
            bus.S_AXI_WVALID  = 1'b1;
        end
        #1;
        if (v.rd) chk("arready", bus.S_AXI_ARREADY, 1);
        else chk("aw_wready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 3);
        tick;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        chk("tx_tvalid", bus.AXIS_TX_TVALID, 1);
        chk_w("tx_tdata", bus.AXIS_TX_TDATA, exp_msg);
        if (v.tx_stall > 0) begin
            repeat (v.tx_stall) tick;
            chk("tx_tvalid_hold", bus.AXIS_TX_TVALID, 1);
            chk_w("tx_tdata_hold", bus.AXIS_TX_TDATA, exp_msg);
        end
        bus.AXIS_TX_TREADY = 1'b1;
        tick;
        bus.AXIS_TX_TREADY = 1'b0;
        chk("tx_tvalid_clr", bus.AXIS_TX_TVALID, 0);
        for (int i = 0; i < v.nw; i++) begin
            send_rsp(v.e_tag + 8'($urandom_range(1, 255)),
                     2'($urandom), $urandom);
        end
        repeat (v.k) tick;
        if (!v.drop) begin
            send_rsp(v.e_tag, v.rsp, v.rdata);
            if (!v.e_tmo) chk("rsp_to_valid_1cyc", cur_valid(v.rd), 1);
        end
        w = 0;
        while (!cur_valid(v.rd) && w < T + 8) begin
            tick;
            w++;
        end
        if (!cur_valid(v.rd)) begin
            n_checks++;
            n_fail++;
            $display("FAIL completion_wait: VALID 0 after %0d cycles, required 1", w);
        end
        for (int p = 0; p < 2; p++) begin
            if (p == 1) begin
                if (v.r_stall == 0) break;
                repeat (v.r_stall) tick;
            end
            if (v.rd) begin
                chk("rvalid", bus.S_AXI_RVALID, 1);
                chk("rresp", bus.S_AXI_RRESP, v.e_resp);
                chk("rdata", bus.S_AXI_RDATA, v.e_rdata);
                chk("bvalid_idle", bus.S_AXI_BVALID, 0);
            end else begin
                chk("bvalid", bus.S_AXI_BVALID, 1);
                chk("bresp", bus.S_AXI_BRESP, v.e_resp);
                chk("rvalid_idle", bus.S_AXI_RVALID, 0);
            end
        end
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_RREADY = 1'b1;
        tick;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        chk("valid_clr", cur_valid(v.rd), 0);
        if (v.drop) send_rsp(v.e_tag, 2'b00, 32'h0);
        chk("stale_count", stale_count, v.e_stale);
        chk("timeout_count", timeout_count, v.e_tmo_cnt);
    endtask

    // Transaction-level reference: match window, stale and timeout rules.
    task automatic model_txn(input vec_t v_in);
        vec_t v;
        bit   matched;
        v = v_in;
        matched = !v.drop && (v.nw + v.k <= T - 1);
        v.e_tag   = m_tag;
        v.e_resp  = matched ? v.rsp : 2'b11;
        v.e_rdata = matched ? v.rdata : 32'hDEADDEAD;
        v.e_tmo   = !matched;
        m_stale   = m_stale + v.nw + (matched ? 0 : 1);
        m_tmo     = m_tmo + (matched ? 0 : 1);
        v.e_stale   = m_stale;
        v.e_tmo_cnt = m_tmo;
        run_txn(v);
        m_tag = m_tag + 8'd1;
    endtask

    task automatic rand_txn;
        vec_t v;
        v.rd       = 1'($urandom_range(0, 1));
        v.addr     = $urandom;
        v.wdata    = $urandom;
        v.strb     = 4'($urandom);
        v.tx_stall = $urandom_range(0, 3);
        v.nw       = $urandom_range(0, 2);
        v.k        = $urandom_range(0, 18);
        v.drop     = ($urandom_range(0, 7) == 0);
        v.rsp      = 2'($urandom);
        v.rdata    = $urandom;
        v.r_stall  = $urandom_range(0, 3);
        v.e_tag    = '0;
        v.e_resp   = '0;
        v.e_rdata  = '0;
        v.e_tmo    = 1'b0;
        v.e_stale  = 0;
        v.e_tmo_cnt = 0;
        model_txn(v);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rd addr wdata strb txs nw k drop rsp rdata rst | tag resp rdata tmo stale tmo_cnt
        tbl[0] = '{0, 32'h1000, 32'hA5A5A5A5, 4'hF, 0, 0, 5, 0, 2'd0, 32'h0,
                   0, 8'd0, 2'd0, 32'h0, 0, 0, 0};
        tbl[1] = '{1, 32'h20, 32'h0, 4'h0, 0, 0, 3, 0, 2'd0, 32'h12345678,
                   3, 8'd1, 2'd0, 32'h12345678, 0, 0, 0};
        tbl[2] = '{1, 32'h40, 32'h0, 4'h0, 1, 0, 0, 1, 2'd0, 32'h0,
                   2, 8'd2, 2'd3, 32'hDEADDEAD, 1, 1, 1};
        tbl[3] = '{1, 32'h44, 32'h0, 4'h0, 0, 1, 2, 0, 2'd0, 32'hCAFEF00D,
                   0, 8'd3, 2'd0, 32'hCAFEF00D, 0, 2, 1};
        tbl[4] = '{0, 32'h80, 32'h1, 4'h3, 2, 0, 0, 0, 2'd2, 32'h0,
                   1, 8'd4, 2'd2, 32'h0, 0, 2, 1};
        tbl[5] = '{1, 32'h84, 32'h0, 4'h0, 0, 0, 15, 0, 2'd1, 32'h0BADBEEF,
                   0, 8'd5, 2'd1, 32'h0BADBEEF, 0, 2, 1};
        tbl[6] = '{1, 32'h88, 32'h0, 4'h0, 0, 0, 16, 0, 2'd0, 32'h11111111,
                   0, 8'd6, 2'd3, 32'hDEADDEAD, 1, 3, 2};
        tbl[7] = '{0, 32'h8C, 32'h55AA, 4'h5, 0, 3, 12, 0, 2'd0, 32'h0,
                   0, 8'd7, 2'd0, 32'h0, 0, 6, 2};
        tbl[8] = '{0, 32'h90, 32'h77, 4'hF, 0, 2, 14, 0, 2'd1, 32'h0,
                   1, 8'd8, 2'd3, 32'h0, 1, 9, 3};

        do_reset;
        for (int i = 0; i < 9; i++) run_txn(tbl[i]);

        // Simultaneous AW/W/AR: write first, then the held read.
        do_reset;
        bus.S_AXI_AWADDR  = 32'h300;
        bus.S_AXI_WDATA   = 32'hFEEDBEEF;
        bus.S_AXI_WSTRB   = 4'hC;
        bus.S_AXI_ARADDR  = 32'h304;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_ARVALID = 1'b1;
        #1;
        chk("both_awready", bus.S_AXI_AWREADY, 1);
        chk("both_arready", bus.S_AXI_ARREADY, 0);
        tick;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        chk_w("both_wr_msg", bus.AXIS_TX_TDATA,
              req_msg(0, 8'd0, 4'hC, 32'h300, 32'hFEEDBEEF));
        chk("send_arready", bus.S_AXI_ARREADY, 0);
        bus.AXIS_TX_TREADY = 1'b1;
        tick;
        bus.AXIS_TX_TREADY = 1'b0;
        send_rsp(8'd0, 2'b00, 32'h0);
        chk("both_bvalid", bus.S_AXI_BVALID, 1);
        chk("respb_arready", bus.S_AXI_ARREADY, 0);
        bus.S_AXI_BREADY = 1'b1;
        tick;
        bus.S_AXI_BREADY = 1'b0;
        chk("idle_arready", bus.S_AXI_ARREADY, 1);
        tick;
        bus.S_AXI_ARVALID = 1'b0;
        chk_w("both_rd_msg", bus.AXIS_TX_TDATA,
              req_msg(1, 8'd1, 4'h0, 32'h304, 32'h0));
        bus.AXIS_TX_TREADY = 1'b1;
        tick;
        bus.AXIS_TX_TREADY = 1'b0;
        send_rsp(8'd1, 2'b00, 32'h600D600D);
        chk("both_rdata", bus.S_AXI_RDATA, 32'h600D600D);
        bus.S_AXI_RREADY = 1'b1;
        tick;
        bus.S_AXI_RREADY = 1'b0;
        m_tag = 8'd2;

        // Randomized run long enough to wrap the 8-bit tag.
        for (int i = 0; i < 300; i++) rand_txn;

        // Reset while a request is stuck in SEND.
        bus.S_AXI_AWADDR  = 32'h500;
        bus.S_AXI_WDATA   = 32'h1;
        bus.S_AXI_WSTRB   = 4'h1;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        tick;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        chk("send_tvalid", bus.AXIS_TX_TVALID, 1);
        resetn = 1'b0;
        tick;
        chk("midrst_tvalid", bus.AXIS_TX_TVALID, 0);
        chk("midrst_bvalid", bus.S_AXI_BVALID, 0);
        chk("midrst_counters", {stale_count, timeout_count}, 0);
        resetn = 1'b1;
        tick;
        chk("postrst_bvalid", bus.S_AXI_BVALID, 0);
        m_tag   = 8'd0;
        m_stale = 0;
        m_tmo   = 0;
        rand_txn;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
